// File: rtl/stack_alu_pkg.sv
// Shared definitions for the stack ALU: opcode encoding, controller states,
// opcode classification masks and the bit positions inside the flags word.
// No ports; imported by stack_alu and stack_alu_core.
package stack_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SLT = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_NOT = 4'd8,
        OP_NEG = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP_A,
        ST_POP_B,
        ST_EXEC,
        ST_PUSH,
        ST_ERR
    } state_e;

    // One bit per opcode value: set for opcodes that take a single operand.
    localparam logic [15:0] UNARY_OPS = 16'h0300;
    // One bit per opcode value: set for opcodes the ALU implements.
    localparam logic [15:0] LEGAL_OPS = 16'h03FF;

    // Bit positions within flags = {N,V,C,Z}.
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;

endpackage

// File: rtl/stack_alu_core.sv
// Purely combinational datapath of the stack ALU.
// Ports:
//   i_op     - opcode (stack_alu_pkg::alu_op_e encoding)
//   i_l      - left operand (second word popped; unused by unary ops)
//   i_r      - right operand (first word popped)
//   o_result - operation result, modulo 2^WIDTH
//   o_flags  - {N,V,C,Z} for this result
module stack_alu_core
    import stack_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_l,
    input  logic [WIDTH-1:0] i_r,
    output logic [WIDTH-1:0] o_result,
    output logic [3:0]       o_flags
);

    localparam int SH_W = $clog2(WIDTH);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_neg;
    logic             w_carry;
    logic             w_ovf;
    logic             w_slt;
    logic [SH_W-1:0]  w_shamt;

    // The top bit of each extended difference is the unsigned borrow.
    assign w_sum   = {1'b0, i_l} + {1'b0, i_r};
    assign w_diff  = {1'b0, i_l} - {1'b0, i_r};
    assign w_neg   = {(WIDTH+1){1'b0}} - {1'b0, i_r};
    assign w_slt   = $signed(i_l) < $signed(i_r);
    assign w_shamt = i_r[SH_W-1:0];

    // Result selection; carry and overflow stay zero except for arithmetic.
    always_comb begin
        o_result = '0;
        w_carry  = 1'b0;
        w_ovf    = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_result = w_sum[WIDTH-1:0];
                w_carry  = w_sum[WIDTH];
                w_ovf    = (i_l[WIDTH-1] == i_r[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != i_l[WIDTH-1]);
            end
            OP_SUB: begin
                o_result = w_diff[WIDTH-1:0];
                w_carry  = w_diff[WIDTH];
                w_ovf    = (i_l[WIDTH-1] != i_r[WIDTH-1]) &&
                           (w_diff[WIDTH-1] != i_l[WIDTH-1]);
            end
            OP_AND: o_result = i_l & i_r;
            OP_OR:  o_result = i_l | i_r;
            OP_XOR: o_result = i_l ^ i_r;
            OP_SLT: o_result = {{(WIDTH-1){1'b0}}, w_slt};
            OP_SHL: o_result = i_l << w_shamt;
            OP_SHR: o_result = i_l >> w_shamt;
            OP_NOT: o_result = ~i_r;
            OP_NEG: begin
                // 0 - R: overflow only when R is the most negative value.
                o_result = w_neg[WIDTH-1:0];
                w_carry  = w_neg[WIDTH];
                w_ovf    = i_r[WIDTH-1] && w_neg[WIDTH-1];
            end
            default: o_result = '0;
        endcase
    end

    always_comb begin
        o_flags         = '0;
        o_flags[FLAG_Z] = (o_result == '0);
        o_flags[FLAG_C] = w_carry;
        o_flags[FLAG_V] = w_ovf;
        o_flags[FLAG_N] = o_result[WIDTH-1];
    end

endmodule

// File: rtl/stack_alu.sv
// Stack-attached ALU controller. Pops one or two operands from an external
// stack, evaluates the opcode and pushes the result back.
// Ports:
//   clock, reset_n      - clock and asynchronous active-low reset
//   op_valid / op_ready - opcode handshake (ready only while idle)
//   alu_op              - opcode, captured on accept
//   stack_top           - current top-of-stack word
//   stack_count         - current stack occupancy
//   pop / push          - one-cycle stack strobes; push_data is the result
//   done / error        - completion pulse, error marks a rejected opcode
//   flags               - {N,V,C,Z} of the last executed operation
module stack_alu
    import stack_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] stack_top,
    input  logic [CNT_W-1:0] stack_count,
    output logic             pop,
    output logic             push,
    output logic [WIDTH-1:0] push_data,
    output logic             done,
    output logic             error,
    output logic [3:0]       flags
);

    state_e           r_state;
    state_e           w_next;
    logic [3:0]       r_opcode;
    logic [WIDTH-1:0] r_l;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;
    logic [CNT_W-1:0] w_need;
    logic [WIDTH-1:0] w_core_result;
    logic [3:0]       w_core_flags;

    stack_alu_core #(.WIDTH(WIDTH)) u_core (
        .i_op     (r_opcode),
        .i_l      (r_l),
        .i_r      (r_r),
        .o_result (w_core_result),
        .o_flags  (w_core_flags)
    );

    assign w_need = UNARY_OPS[alu_op] ? CNT_W'(1) : CNT_W'(2);

    // Next-state logic. Legality and operand availability are judged once,
    // at accept, so later changes to stack_count cannot affect the operation.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (op_valid) begin
                    if (!LEGAL_OPS[alu_op] || (stack_count < w_need)) begin
                        w_next = ST_ERR;
                    end else begin
                        w_next = ST_POP_A;
                    end
                end
            end
            ST_POP_A: w_next = UNARY_OPS[r_opcode] ? ST_EXEC : ST_POP_B;
            ST_POP_B: w_next = ST_EXEC;
            ST_EXEC:  w_next = ST_PUSH;
            ST_PUSH:  w_next = ST_IDLE;
            ST_ERR:   w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // State, operand, result and flag registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_opcode <= '0;
            r_l      <= '0;
            r_r      <= '0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == ST_IDLE) && op_valid) begin
                r_opcode <= alu_op;
                r_l      <= '0;
                r_r      <= '0;
            end
            if (r_state == ST_POP_A) begin
                r_r <= stack_top;
            end
            if (r_state == ST_POP_B) begin
                r_l <= stack_top;
            end
            if (r_state == ST_EXEC) begin
                r_result <= w_core_result;
                r_flags  <= w_core_flags;
            end
        end
    end

    // Strobes decode directly from the state, so pop and push are exclusive.
    assign op_ready  = (r_state == ST_IDLE);
    assign pop       = (r_state == ST_POP_A) || (r_state == ST_POP_B);
    assign push      = (r_state == ST_PUSH);
    assign done      = (r_state == ST_PUSH) || (r_state == ST_ERR);
    assign error     = (r_state == ST_ERR);
    assign push_data = r_result;
    assign flags     = r_flags;

endmodule

// File: tb/tb_stack_alu.sv
// Directed self-checking bench for stack_alu (WIDTH=32, CNT_W=8).
module tb_stack_alu;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [3:0]  alu_op = 4'd0;
    logic [31:0] stack_top = 32'd0;
    logic [7:0]  stack_count = 8'd0;
    logic        pop;
    logic        push;
    logic [31:0] push_data;
    logic        done;
    logic        error;
    logic [3:0]  flags;

    int checks = 0;
    int failures = 0;

    // Observations recorded by doOp for the calling test to compare.
    int          obsPops;
    int          obsFirstPop;
    int          obsPushCycle;
    int          obsDoneCycle;
    logic        obsErr;
    logic        obsBoth;
    logic        obsBusyReady;
    logic        obsReadyAfter;
    logic [31:0] obsData;
    logic [3:0]  obsFlags;

    stack_alu #(.WIDTH(32), .CNT_W(8)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .alu_op      (alu_op),
        .stack_top   (stack_top),
        .stack_count (stack_count),
        .pop         (pop),
        .push        (push),
        .push_data   (push_data),
        .done        (done),
        .error       (error),
        .flags       (flags)
    );

    always #5 clock = ~clock;

    // Issues one opcode and plays the stack: t1 is on top at accept and t2
    // appears after the first pop. op_valid stays high and alu_op/stack_count
    // are scrambled while busy, all of which the DUT must ignore.
    task automatic doOp(input logic [3:0] op, input logic [7:0] cnt,
                        input logic [31:0] t1, input logic [31:0] t2);
        logic popNow;
        obsPops = 0; obsFirstPop = 0; obsPushCycle = 0; obsDoneCycle = 0;
        obsErr = 1'b0; obsBoth = 1'b0; obsBusyReady = 1'b0;
        obsData = 32'd0; obsFlags = 4'd0;
        @(negedge clock);
        op_valid = 1'b1; alu_op = op; stack_count = cnt; stack_top = t1;
        @(posedge clock); #1;
        alu_op = 4'hF; stack_count = 8'd0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (pop) begin
                obsPops++;
                if (obsFirstPop == 0) obsFirstPop = cyc;
            end
            if (pop && push) obsBoth = 1'b1;
            if (op_ready) obsBusyReady = 1'b1;
            if (push) begin obsPushCycle = cyc; obsData = push_data; end
            if (error) obsErr = 1'b1;
            if (done) begin
                obsDoneCycle = cyc; obsFlags = flags; op_valid = 1'b0;
                break;
            end
            popNow = pop;
            @(posedge clock); #1;
            if (popNow && obsPops == 1) stack_top = t2;
        end
        op_valid = 1'b0; alu_op = 4'd0;
        @(posedge clock); #1;
        obsReadyAfter = op_ready;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++; if ({op_ready, pop, push, done, error} !== 5'b10000) begin failures++; $display("[TB] FAIL reset_ctrl got=%b exp=%b", {op_ready, pop, push, done, error}, 5'b10000); end
        checks++; if (push_data !== 32'd0) begin failures++; $display("[TB] FAIL reset_data got=%h exp=%h", push_data, 32'd0); end
        checks++; if (flags !== 4'd0) begin failures++; $display("[TB] FAIL reset_flags got=%b exp=%b", flags, 4'd0); end
        @(negedge clock); reset_n = 1'b1;
    endtask

    task automatic test_add;
        doOp(4'd0, 8'd2, 32'd5, 32'd3);
        checks++; if (obsData !== 32'd8) begin failures++; $display("[TB] FAIL add_data got=%h exp=%h", obsData, 32'd8); end
        checks++; if (obsPushCycle !== 4) begin failures++; $display("[TB] FAIL add_push_cycle got=%0d exp=4", obsPushCycle); end
        checks++; if (obsDoneCycle !== 4) begin failures++; $display("[TB] FAIL add_done_cycle got=%0d exp=4", obsDoneCycle); end
        checks++; if (obsPops !== 2 || obsFirstPop !== 1) begin failures++; $display("[TB] FAIL add_pops got=%0d@%0d exp=2@1", obsPops, obsFirstPop); end
        checks++; if (obsFlags !== 4'b0000) begin failures++; $display("[TB] FAIL add_flags got=%b exp=0000", obsFlags); end
        checks++; if ({obsErr, obsBoth, obsBusyReady} !== 3'b000) begin failures++; $display("[TB] FAIL add_err_both_ready got=%b exp=000", {obsErr, obsBoth, obsBusyReady}); end
        checks++; if (obsReadyAfter !== 1'b1) begin failures++; $display("[TB] FAIL add_ready_after got=%b exp=1", obsReadyAfter); end
        doOp(4'd0, 8'd7, 32'd1, 32'hFFFF_FFFF);
        checks++; if ({obsData, obsFlags} !== {32'd0, 4'b0011}) begin failures++; $display("[TB] FAIL add_carry got=%h/%b exp=00000000/0011", obsData, obsFlags); end
    endtask

    task automatic test_sub;
        doOp(4'd1, 8'd2, 32'd3, 32'd5);
        checks++; if ({obsData, obsFlags} !== {32'd2, 4'b0000}) begin failures++; $display("[TB] FAIL sub_pos got=%h/%b exp=00000002/0000", obsData, obsFlags); end
        doOp(4'd1, 8'd2, 32'd5, 32'd3);
        checks++; if ({obsData, obsFlags} !== {32'hFFFF_FFFE, 4'b1010}) begin failures++; $display("[TB] FAIL sub_neg got=%h/%b exp=fffffffe/1010", obsData, obsFlags); end
    endtask

    task automatic test_overflow;
        doOp(4'd0, 8'd2, 32'd1, 32'h7FFF_FFFF);
        checks++; if ({obsData, obsFlags} !== {32'h8000_0000, 4'b1100}) begin failures++; $display("[TB] FAIL add_ovf got=%h/%b exp=80000000/1100", obsData, obsFlags); end
    endtask

    task automatic test_errors;
        doOp(4'd0, 8'd1, 32'd9, 32'd9);
        checks++; if ({obsErr, obsDoneCycle} !== {1'b1, 32'd1}) begin failures++; $display("[TB] FAIL err_count got=%b@%0d exp=1@1", obsErr, obsDoneCycle); end
        checks++; if (obsPops !== 0 || obsPushCycle !== 0) begin failures++; $display("[TB] FAIL err_count_strobes got=pops%0d/push%0d exp=pops0/push0", obsPops, obsPushCycle); end
        checks++; if (obsFlags !== 4'b1100) begin failures++; $display("[TB] FAIL err_count_flags got=%b exp=1100", obsFlags); end
        doOp(4'd12, 8'd5, 32'd9, 32'd9);
        checks++; if ({obsErr, obsDoneCycle, obsPops} !== {1'b1, 32'd1, 32'd0}) begin failures++; $display("[TB] FAIL err_illegal got=err%b@%0d pops%0d exp=err1@1 pops0", obsErr, obsDoneCycle, obsPops); end
        checks++; if (obsFlags !== 4'b1100) begin failures++; $display("[TB] FAIL err_illegal_flags got=%b exp=1100", obsFlags); end
        doOp(4'd9, 8'd0, 32'd9, 32'd9);
        checks++; if ({obsErr, obsDoneCycle, obsPops} !== {1'b1, 32'd1, 32'd0}) begin failures++; $display("[TB] FAIL err_unary_empty got=err%b@%0d pops%0d exp=err1@1 pops0", obsErr, obsDoneCycle, obsPops); end
    endtask

    task automatic test_logic_shift;
        doOp(4'd4, 8'd2, 32'h0000_FF00, 32'h0000_F0F0);
        checks++; if (obsData !== 32'h0000_0FF0) begin failures++; $display("[TB] FAIL xor got=%h exp=00000ff0", obsData); end
        doOp(4'd2, 8'd2, 32'h0000_FF00, 32'h0000_F0F0);
        checks++; if (obsData !== 32'h0000_F000) begin failures++; $display("[TB] FAIL and got=%h exp=0000f000", obsData); end
        doOp(4'd3, 8'd2, 32'h0000_FF00, 32'h0000_F0F0);
        checks++; if (obsData !== 32'h0000_FFF0) begin failures++; $display("[TB] FAIL or got=%h exp=0000fff0", obsData); end
        doOp(4'd5, 8'd2, 32'd1, 32'hFFFF_FFFF);
        checks++; if ({obsData, obsFlags} !== {32'd1, 4'b0000}) begin failures++; $display("[TB] FAIL slt_true got=%h/%b exp=00000001/0000", obsData, obsFlags); end
        doOp(4'd5, 8'd2, 32'hFFFF_FFFF, 32'd1);
        checks++; if ({obsData, obsFlags} !== {32'd0, 4'b0001}) begin failures++; $display("[TB] FAIL slt_false got=%h/%b exp=00000000/0001", obsData, obsFlags); end
        doOp(4'd6, 8'd2, 32'd36, 32'd1);
        checks++; if (obsData !== 32'd16) begin failures++; $display("[TB] FAIL shl got=%h exp=00000010", obsData); end
        doOp(4'd7, 8'd2, 32'd31, 32'h8000_0000);
        checks++; if ({obsData, obsFlags} !== {32'd1, 4'b0000}) begin failures++; $display("[TB] FAIL shr got=%h/%b exp=00000001/0000", obsData, obsFlags); end
    endtask

    task automatic test_unary;
        doOp(4'd8, 8'd1, 32'hFFFF_FFFF, 32'h1234_5678);
        checks++; if ({obsData, obsFlags} !== {32'd0, 4'b0001}) begin failures++; $display("[TB] FAIL not got=%h/%b exp=00000000/0001", obsData, obsFlags); end
        checks++; if (obsPushCycle !== 3 || obsPops !== 1) begin failures++; $display("[TB] FAIL not_timing got=push@%0d pops%0d exp=push@3 pops1", obsPushCycle, obsPops); end
        doOp(4'd9, 8'd3, 32'd1, 32'd7);
        checks++; if ({obsData, obsFlags} !== {32'hFFFF_FFFF, 4'b1010}) begin failures++; $display("[TB] FAIL neg_one got=%h/%b exp=ffffffff/1010", obsData, obsFlags); end
        doOp(4'd9, 8'd1, 32'h8000_0000, 32'd7);
        checks++; if ({obsData, obsFlags} !== {32'h8000_0000, 4'b1110}) begin failures++; $display("[TB] FAIL neg_min got=%h/%b exp=80000000/1110", obsData, obsFlags); end
    endtask

    task automatic test_reset_mid_op;
        logic strobeSeen;
        strobeSeen = 1'b0;
        @(negedge clock);
        op_valid = 1'b1; alu_op = 4'd0; stack_count = 8'd2; stack_top = 32'd11;
        @(posedge clock); #1;
        op_valid = 1'b0;
        @(posedge clock); #1;
        stack_top = 32'd22;
        checks++; if (pop !== 1'b1) begin failures++; $display("[TB] FAIL midrst_in_pop_b got=%b exp=1", pop); end
        reset_n = 1'b0;
        #1;
        checks++; if ({op_ready, pop, push, done, error} !== 5'b10000) begin failures++; $display("[TB] FAIL midrst_ctrl got=%b exp=10000", {op_ready, pop, push, done, error}); end
        checks++; if ({push_data, flags} !== {32'd0, 4'd0}) begin failures++; $display("[TB] FAIL midrst_data_flags got=%h/%b exp=00000000/0000", push_data, flags); end
        @(negedge clock); reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            if (pop || push || done) strobeSeen = 1'b1;
        end
        checks++; if (strobeSeen !== 1'b0) begin failures++; $display("[TB] FAIL midrst_no_strobes got=%b exp=0", strobeSeen); end
        checks++; if (op_ready !== 1'b1) begin failures++; $display("[TB] FAIL midrst_ready got=%b exp=1", op_ready); end
        doOp(4'd0, 8'd2, 32'd10, 32'd20);
        checks++; if ({obsData, obsPushCycle, obsPops} !== {32'd30, 32'd4, 32'd2}) begin failures++; $display("[TB] FAIL midrst_next_add got=%h push@%0d pops%0d exp=0000001e push@4 pops2", obsData, obsPushCycle, obsPops); end
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub;
        test_overflow;
        test_errors;
        test_logic_shift;
        test_unary;
        test_reset_mid_op;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
